// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional alignment checking is enabled with PC_SEQ_ALIGN_CHECK_EN.
package pc_seq_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD
   } state_e;

   typedef enum logic [2:0] {
      RD_NONE,
      RD_BR,
      RD_J,
      RD_JR,
      RD_EXC
   } rd_src_e;

   // J-type target keeps the region bits of the delay-slot address.
   function automatic logic [31:0] jump_addr(
      input logic [31:0] pc4,
      input logic [25:0] index
   );
      return {pc4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Redirect priority select and target formation for the PC sequencer.
// With PC_SEQ_ALIGN_CHECK_EN a misaligned jr/branch target is flagged.
module next_pc_sel
   import pc_seq_pkg::*;
(
   input  logic        stall,
   input  logic        exc,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        branch,
   input  logic [31:0] branch_target,
   input  logic [31:0] pc4,
   output rd_src_e     src,
`ifdef PC_SEQ_ALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic [31:0] target
);

   logic        sel_exc;
   logic        sel_jr;
   logic        sel_j;
   logic        sel_br;
   logic [31:0] raw;

   // One-hot grant: exception beats everything, stall masks the rest.
   assign sel_exc = exc;
   assign sel_jr = !exc && !stall && jr;
   assign sel_j = !exc && !stall && !jr && jump;
   assign sel_br = !exc && !stall && !jr && !jump && branch;

   always_comb begin
      src = RD_NONE;
      raw = pc4;
      unique case (1'b1)
         sel_exc: src = RD_EXC;
         sel_jr: begin
            src = RD_JR;
            raw = jr_target;
         end
         sel_j: begin
            src = RD_J;
            raw = jump_addr(pc4, jump_index);
         end
         sel_br: begin
            src = RD_BR;
            raw = branch_target;
         end
         default: src = RD_NONE;
      endcase
   end

`ifdef PC_SEQ_ALIGN_CHECK_EN
   assign misalign = (sel_jr || sel_br) && (raw[1:0] != 2'b00);
   assign target = raw;
`else
   assign target = {raw[31:2], 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer.
// Build with PC_SEQ_ALIGN_CHECK_EN to trap misaligned jr/branch targets.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = pc_seq_pkg::DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR = pc_seq_pkg::DEF_EXC_VECTOR,
   parameter int unsigned INSTR_BYTES = pc_seq_pkg::INSTR_BYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [25:0] jump_target_i,
   input  logic        jr_i,
   input  logic [31:0] jr_target_i,
   input  logic        exc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic        valid_o,
`ifdef PC_SEQ_ALIGN_CHECK_EN
   output logic        misalign_o,
`endif
   output logic [31:0] epc_o
);

   import pc_seq_pkg::*;

   state_e      state;
   rd_src_e     src;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] epc;
   logic [31:0] target;
   logic        valid;
`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic        misalign;
   logic        misalign_q;
`endif

   assign pc4 = pc + 32'(INSTR_BYTES);

   next_pc_sel u_sel (
      .stall        (stall_i),
      .exc          (exc_i),
      .jr           (jr_i),
      .jr_target    (jr_target_i),
      .jump         (jump_i),
      .jump_index   (jump_target_i),
      .branch       (branch_taken_i),
      .branch_target(branch_target_i),
      .pc4          (pc4),
      .src          (src),
`ifdef PC_SEQ_ALIGN_CHECK_EN
      .misalign     (misalign),
`endif
      .target       (target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc <= RESET_VECTOR;
         epc <= 32'h0;
         valid <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
         unique case (state)
            BOOT: state <= FETCH;
            FETCH: begin
               if (src == RD_EXC) begin
                  pc <= EXC_VECTOR;
                  epc <= pc;
                  valid <= 1'b0;
               end else if (stall_i) begin
                  // Any ready data this cycle is dropped and refetched.
                  state <= HOLD;
               end else if (src != RD_NONE) begin
                  valid <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                  if (misalign) begin
                     pc <= EXC_VECTOR;
                     epc <= target;
                     misalign_q <= 1'b1;
                  end else begin
                     pc <= target;
                  end
`else
                  pc <= target;
`endif
               end else if (imem_ready_i) begin
                  pc <= pc4;
                  valid <= 1'b1;
               end else begin
                  valid <= 1'b0;
               end
            end
            HOLD: begin
               if (src == RD_EXC) begin
                  pc <= EXC_VECTOR;
                  epc <= pc;
                  valid <= 1'b0;
                  state <= FETCH;
               end else if (!stall_i) begin
                  state <= FETCH;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   assign imem_req_o = (state == FETCH);
   assign imem_addr_o = pc;
   assign pc_o = pc;
   assign pc4_o = pc4;
   assign valid_o = valid;
   assign epc_o = epc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
   assign misalign_o = misalign_q;
`endif

endmodule
